piso_bit_serializer: RTL and testbench

//   Parallel-in/serial-out stage feeding the serial-bit sequence detector.

---
 rtl/piso_bit_serializer.sv | 86 ++++++++
 tb/tb_piso_bit_serializer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out stage: takes WIDTH-bit words over valid/ready and emits one bit per clk
// on x_out, with back-to-back words contiguous so multi-word patterns reach the detector unbroken.
module piso_bit_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x_out,
    output logic             x_valid,
    output logic             word_done
);

    localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
    localparam logic             ONE_BIT  = (WIDTH == 1);

    typedef enum logic {StIdle, StShift} state_t;

    state_t           state;
    logic [WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0] bit_cnt;

    logic             accept;
    logic             first_bit;
    logic             next_bit;
    logic [WIDTH-1:0] din_rest;
    logic [WIDTH-1:0] shift_rest;

    // Ready on the last bit as well as in idle, so the next word follows with no gap.
    always_comb begin
        din_ready = !reset && ((state == StIdle) || (bit_cnt == '0));
        accept    = din_valid && din_ready;
    end

    // shift_reg holds the bits still to be sent, next one always at the outgoing end.
    always_comb begin
        if (MSB_FIRST) begin
            first_bit  = din[WIDTH-1];
            din_rest   = din << 1;
            next_bit   = shift_reg[WIDTH-1];
            shift_rest = shift_reg << 1;
        end else begin
            first_bit  = din[0];
            din_rest   = din >> 1;
            next_bit   = shift_reg[0];
            shift_rest = shift_reg >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StIdle;
            shift_reg <= '0;
            bit_cnt   <= '0;
            x_out     <= 1'b0;
            x_valid   <= 1'b0;
            word_done <= 1'b0;
        end else if (accept) begin
            state     <= StShift;
            shift_reg <= din_rest;
            bit_cnt   <= LAST_IDX;
            x_out     <= first_bit;
            x_valid   <= 1'b1;
            word_done <= ONE_BIT;
        end else if ((state == StShift) && (bit_cnt != '0)) begin
            shift_reg <= shift_rest;
            bit_cnt   <= bit_cnt - CNT_W'(1);
            x_out     <= next_bit;
            x_valid   <= 1'b1;
            word_done <= (bit_cnt == CNT_W'(1));
        end else begin
            // Idle, or last bit sent with nothing queued: hold x low for the detector.
            state     <= StIdle;
            shift_reg <= '0;
            bit_cnt   <= '0;
            x_out     <= 1'b0;
            x_valid   <= 1'b0;
            word_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Runs three serializer configurations in lockstep on shared stimulus and compares every output
// each cycle against a queue-of-bits reference model.
module tb_piso_bit_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic       din_valid;
    logic [7:0] din;

    logic [2:0] rdy, xo, xv, wd;

    always #5 clk = ~clk;

    piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(rdy[0]), .x_out(xo[0]), .x_valid(xv[0]), .word_done(wd[0])
    );
    piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(rdy[1]), .x_out(xo[1]), .x_valid(xv[1]), .word_done(wd[1])
    );
    piso_bit_serializer #(.WIDTH(1), .MSB_FIRST(1'b1)) u_one (
        .clk(clk), .reset(reset), .din(din[0:0]), .din_valid(din_valid),
        .din_ready(rdy[2]), .x_out(xo[2]), .x_valid(xv[2]), .word_done(wd[2])
    );

    // Reference: each instance owns a queue of {done, bit} still to be shown after this cycle.
    logic [1:0] q [3][$];
    logic       cur_bit  [3];
    logic       cur_val  [3];
    logic       cur_done [3];
    int         widths   [3] = '{8, 8, 1};
    bit         msbf     [3] = '{1'b1, 1'b0, 1'b1};
    string      names    [3] = '{"msb8", "lsb8", "w1"};

    int checks = 0;
    int errors = 0;
    bit out_check_en = 1'b0;

    task automatic chk(input string tag, input int k, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%s] observed=%b expected=%b", tag, names[k], obs, exp);
        end
    endtask

    task automatic cycle(input logic r, input logic v, input logic [7:0] d);
        bit acc [3];
        reset     = r;
        din_valid = v;
        din       = d;
        #1;
        for (int k = 0; k < 3; k++) begin
            logic exp_rdy;
            exp_rdy = !r && (q[k].size() == 0);
            chk("din_ready", k, rdy[k], exp_rdy);
            if (out_check_en) begin
                chk("x_valid", k, xv[k], cur_val[k]);
                chk("x_out", k, xo[k], cur_bit[k]);
                chk("word_done", k, wd[k], cur_done[k]);
            end
            acc[k] = v && exp_rdy;
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (r) begin
                q[k].delete();
                cur_val[k] = 1'b0;
                cur_bit[k] = 1'b0;
                cur_done[k] = 1'b0;
            end else begin
                if (acc[k]) begin
                    for (int i = 0; i < widths[k]; i++) begin
                        int idx;
                        idx = msbf[k] ? widths[k] - 1 - i : i;
                        q[k].push_back({(i == widths[k] - 1), d[idx]});
                    end
                end
                if (q[k].size() > 0) begin
                    logic [1:0] it;
                    it = q[k].pop_front();
                    cur_val[k] = 1'b1;
                    cur_bit[k] = it[0];
                    cur_done[k] = it[1];
                end else begin
                    cur_val[k] = 1'b0;
                    cur_bit[k] = 1'b0;
                    cur_done[k] = 1'b0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        reset = 1'b1;
        din_valid = 1'b0;
        din = 8'h00;
        @(negedge clk);
        cycle(1'b1, 1'b0, 8'h00);
        out_check_en = 1'b1;
        cycle(1'b1, 1'b0, 8'h00);

        // Single word, MSB first: 1,0,1,0,0,0,0,0 on msb8.
        cycle(1'b0, 1'b1, 8'hA0);
        idle(10);

        // Back-to-back words with valid held until accepted.
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'h01);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'h40);
        idle(10);

        // Word offered mid-flight is ignored until the last bit.
        cycle(1'b0, 1'b1, 8'hA5);
        idle(2);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 8'hFF);
        idle(10);

        // Reset in the middle of a word.
        cycle(1'b0, 1'b1, 8'hA5);
        idle(3);
        cycle(1'b1, 1'b0, 8'h00);
        idle(3);

        // LSB-first pattern and single-bit stream 1,0,1.
        cycle(1'b0, 1'b1, 8'h05);
        idle(9);
        cycle(1'b0, 1'b1, 8'h01);
        cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b1, 8'h01);
        idle(10);

        // Random traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            logic r;
            logic v;
            r = ($urandom_range(0, 39) == 0);
            v = ($urandom_range(0, 3) != 0);
            cycle(r, v, 8'($urandom));
        end
        idle(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
